process_element_mul_arbiter: RTL and testbench
==============================================

// Module: process_element_mul_arbiter
// PURPOSE
//  Shares one pipelined signed-by-unsigned multiplier (7s x 15ns -> 22) among
//  NUM_REQ requesters inside the processing element. Round-robin arbitration
//  picks at most one operand pair per cycle, drives the multiplier clock enable,
//  and tracks requester IDs through the pipeline. Returns each product with its
//  ID on one result channel that supports backpressure.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  A_WIDTH  7   signed operand width
//  B_WIDTH  15  unsigned operand width
//  P_WIDTH  22  product width (A_WIDTH+B_WIDTH)
//  LATENCY  3   enabled cycles from din sampled to dout valid (>=1)
//  ID_W     2   clog2(NUM_REQ), minimum 1
// PORTS
//  clk        in   1                clock, rising edge
//  reset      in   1                synchronous, active-high
//  req_valid  in   NUM_REQ          operand pair i valid
//  req_ready  out  NUM_REQ          pair i accepted this cycle (one-hot or 0)
//  req_a      in   NUM_REQ*A_WIDTH  signed operands, slice i = [i*A_WIDTH +: A_WIDTH]
//  req_b      in   NUM_REQ*B_WIDTH  unsigned operands, same slicing
//  mul_ce     out  1                multiplier clock enable
//  mul_din0   out  A_WIDTH          to multiplier din0
//  mul_din1   out  B_WIDTH          to multiplier din1
//  mul_dout   in   P_WIDTH          from multiplier dout
//  res_valid  out  1                result valid
//  res_ready  in   1                consumer accepts result
//  res_id     out  ID_W             requester index of the result
//  res_p      out  P_WIDTH          signed product (= mul_dout)
//  busy       out  1                any valid stage in flight
// BEHAVIOUR
//  - Reset: vld_pipe=0, id_pipe=0, rr_ptr=0. Then res_valid=0, busy=0,
//    req_ready=0, mul_ce=0 while reset is high.
//  - Stall: stall = vld_pipe[LATENCY-1] & ~res_ready. mul_ce = ~reset & ~stall.
//    vld_pipe/id_pipe shift only when mul_ce=1, in lockstep with the multiplier.
//  - Arbitration (combinational, only when mul_ce=1): search from rr_ptr upward,
//    with wrap, for the first req_valid. Grant g gives req_ready[g]=1, and
//    mul_din0/1 = slice g. On a grant, rr_ptr <= (g+1) mod NUM_REQ. With no
//    grant, rr_ptr holds and a bubble (valid 0) enters the pipe.
//  - Without a grant, mul_din0/1 hold slice rr_ptr. The value is irrelevant
//    because the stage is invalid.
//  - req_ready may depend on req_valid and res_ready (no loop back to them).
//    Requesters hold valid and data stable until ready. Transfer = valid & ready.
//  - Latency: a pair accepted at edge t gives res_valid=1 after edge
//    t+LATENCY-1 when there are no stalls. Throughput: 1 result/cycle sustained.
//  - Result: res_valid = vld_pipe[LATENCY-1], res_id = id_pipe[LATENCY-1],
//    res_p = mul_dout. While stalled, all of these hold steady because the
//    multiplier is frozen by mul_ce=0.
//  - Result handshake with a simultaneous grant: a result leaves and a new pair
//    enters in the same cycle (no bubble).
//  - Arithmetic: product = $signed(a) * $signed({1'b0,b}). Full 22-bit range,
//    no saturation. Extremes -64*32767 = -2097088 and 63*32767 = 2064321.
//  - Reset during operation: all in-flight results are discarded without
//    being presented, and rr_ptr returns to 0.
//  - busy = |vld_pipe.
// TESTING
//  1 Reset with req_valid=4'b1111 -> req_ready=0, mul_ce=0, res_valid=0. First
//    cycle after release grants req 0.
//  2 Single op: req1 a=-3, b=1000, res_ready=1 -> res_valid exactly 3 cycles
//    later, res_id=1, res_p=-3000.
//  3 All 4 valid continuously -> grants 0,1,2,3,0,... one per cycle. Results
//    arrive in the same order, with no bubbles.
//  4 res_ready=0 for 5 cycles while 3 ops are in flight -> mul_ce=0, no grants,
//    res_p/res_id stable. After release, results arrive in order, none lost or
//    duplicated.
//  5 Extremes: a=-64, b=32767 -> -2097088; a=63, b=32767 -> 2064321;
//    a=0, b=x -> 0.
//  6 Assert reset 1 cycle after 2 grants -> no res_valid for those ops, and
//    the next grant goes to req 0.

Source files
------------

// File: rtl/process_element_mul_arbiter.sv
// Round-robin front end for one shared pipelined signed x unsigned multiplier.
// Tracks requester IDs alongside the multiplier pipeline and presents products on one backpressured channel.
module process_element_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 7,
  parameter int B_WIDTH = 15,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH,
  parameter int LATENCY = 3,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         mul_ce,
  output logic [A_WIDTH-1:0]           mul_din0,
  output logic [B_WIDTH-1:0]           mul_din1,
  input  logic [P_WIDTH-1:0]           mul_dout,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_W-1:0]              res_id,
  output logic [P_WIDTH-1:0]           res_p,
  output logic                         busy
);

  logic [LATENCY-1:0] vld_pipe;
  logic [ID_W-1:0]    id_pipe [LATENCY];
  logic [ID_W-1:0]    rr_ptr;

  logic               stall;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;

  // The whole pipeline (ours and the multiplier's) freezes while the head result waits.
  assign stall  = vld_pipe[LATENCY-1] & ~res_ready;
  assign mul_ce = ~reset & ~stall;

  // NOTE: every variable assigned in this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_id    = rr_ptr;
    req_ready   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (mul_ce && !grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
    if (grant_valid) req_ready[grant_id] = 1'b1;
  end

  // With no grant grant_id equals rr_ptr; the operands then ride an invalid stage.
  assign mul_din0 = req_a[int'(grant_id)*A_WIDTH +: A_WIDTH];
  assign mul_din1 = req_b[int'(grant_id)*B_WIDTH +: B_WIDTH];

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      rr_ptr   <= '0;
      // NOTE: id_pipe is a small register array, not RAM, so clearing it on reset costs nothing special.
      for (int i = 0; i < LATENCY; i++) id_pipe[i] <= '0;
    end else if (mul_ce) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      vld_pipe[0] <= grant_valid;
      id_pipe[0]  <= grant_id;
      if (grant_valid) begin
        if (grant_id == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
        else                                rr_ptr <= grant_id + 1'b1;
      end
    end
  end

  assign res_valid = vld_pipe[LATENCY-1];
  assign res_id    = id_pipe[LATENCY-1];
  assign res_p     = mul_dout;
  assign busy      = |vld_pipe;

endmodule

// File: tb/tb_process_element_mul_arbiter.sv
// Directed bench: models the external 3-stage multiplier and checks arbitration, latency, stall and reset.
module tb_process_element_mul_arbiter;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int BW = 15;
  localparam int PW = 22;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic              mul_ce;
  logic [AW-1:0]     mul_din0;
  logic [BW-1:0]     mul_din1;
  logic [PW-1:0]     mul_dout;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [PW-1:0]     res_p;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  process_element_mul_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_p(res_p),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: three enabled stages, signed a times zero-extended b.
  logic signed [PW-1:0] m_pipe [3];
  always @(posedge clk) begin
    if (mul_ce) begin
      m_pipe[0] <= $signed(mul_din0) * $signed({1'b0, mul_din1});
      m_pipe[1] <= m_pipe[0];
      m_pipe[2] <= m_pipe[1];
    end
  end
  assign mul_dout = m_pipe[2];

  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  vec_t vecs[6];
  int   exp_p[4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i: a = -(i+2), b = 1000+i.
  task automatic load_all();
    for (int i = 0; i < NR; i++) begin
      req_a[i*AW +: AW] = AW'(-(i + 2));
      req_b[i*BW +: BW] = BW'(1000 + i);
    end
  endtask

  task automatic check_res(input string name, input int id, input int p);
    check({name, "_valid"}, int'(res_valid), 1);
    check({name, "_id"}, int'(res_id), id);
    check({name, "_p"}, int'($signed(res_p)), p);
  endtask

  initial begin
    vecs[0] = '{id: 1, a: -3,  b: 1000,  p: -3000};
    vecs[1] = '{id: 0, a: -64, b: 32767, p: -2097088};
    vecs[2] = '{id: 3, a: 63,  b: 32767, p: 2064321};
    vecs[3] = '{id: 2, a: 0,   b: 12345, p: 0};
    vecs[4] = '{id: 1, a: -1,  b: 1,     p: -1};
    vecs[5] = '{id: 3, a: 5,   b: 100,   p: 500};
    exp_p   = '{-2000, -3003, -4008, -5015};

    // Reset with every requester asking.
    reset     = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    load_all();
    tick();
    tick();
    check("rst_ready", int'(req_ready), 0);
    check("rst_ce", int'(mul_ce), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);

    // Continuous requests: strict rotation, results back-to-back in order.
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      req_valid = (k <= 10) ? 4'hf : 4'h0;
      #1;
      check($sformatf("rr_ready_%0d", k), int'(req_ready), (k <= 10) ? (1 << (k % 4)) : 0);
      if (k >= 3) check_res($sformatf("rr_res_%0d", k), (k - 3) % 4, exp_p[(k - 3) % 4]);
      else        check($sformatf("rr_early_%0d", k), int'(res_valid), 0);
      tick();
    end
    check("rr_drain_valid", int'(res_valid), 0);
    check("rr_drain_busy", int'(busy), 0);

    // Single operations from the table: latency and arithmetic extremes.
    foreach (vecs[v]) begin
      req_a = '0;
      req_b = '0;
      req_a[vecs[v].id*AW +: AW] = AW'(vecs[v].a);
      req_b[vecs[v].id*BW +: BW] = BW'(vecs[v].b);
      req_valid = NR'(1 << vecs[v].id);
      #1;
      check($sformatf("vec%0d_ready", v), int'(req_ready), 1 << vecs[v].id);
      tick();
      req_valid = '0;
      check($sformatf("vec%0d_lat1", v), int'(res_valid), 0);
      tick();
      check($sformatf("vec%0d_lat2", v), int'(res_valid), 0);
      tick();
      check_res($sformatf("vec%0d", v), vecs[v].id, vecs[v].p);
      tick();
      check($sformatf("vec%0d_after", v), int'(res_valid), 0);
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
    end

    // Backpressure: three ops in flight, consumer stalls for five cycles.
    load_all();
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("st_ready_%0d", k), int'(req_ready), 1 << k);
      tick();
    end
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("st_ce_%0d", k), int'(mul_ce), 0);
      check($sformatf("st_noready_%0d", k), int'(req_ready), 0);
      check_res($sformatf("st_hold_%0d", k), 0, exp_p[0]);
      tick();
    end
    res_ready = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_res($sformatf("st_out_%0d", k), k, exp_p[k]);
      tick();
    end
    check("st_end_valid", int'(res_valid), 0);
    check("st_end_busy", int'(busy), 0);

    // Reset one cycle after two grants (pointer sits at 3): results dropped, pointer back to 0.
    req_valid = '1;
    #1;
    check("rs_grant_a", int'(req_ready), 4'b1000);
    tick();
    check("rs_grant_b", int'(req_ready), 4'b0001);
    tick();
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("rs_ready_in_reset", int'(req_ready), 0);
    tick();
    reset     = 1'b0;
    req_valid = 4'b0001 | 4'b0010;
    #1;
    check("rs_busy_cleared", int'(busy), 0);
    check("rs_first_grant", int'(req_ready), 4'b0001);
    tick();
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rs_discard_%0d", k), int'(res_valid), 0);
      tick();
    end
    check_res("rs_new", 0, exp_p[0]);
    tick();
    check("rs_final_valid", int'(res_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
